// File: rtl/uart_dbg_frame_rx.sv
// uart_dbg_frame_rx
//   Assembles 35-byte debug download frames from the UART byte stream
//   (index, 32 payload bytes, CRC16-Modbus lo/hi), validates them, captures
//   the firmware size from frame 0 and writes payload frames into
//   instruction memory as 8 little-endian words. Every complete frame is
//   answered with ACK (0x06) or NACK (0x15).
//
//   Optional: define UART_DBG_TIMEOUT_EN to discard partial frames that go
//   idle for TIMEOUT_CYCLES cycles.
//
// Ports
//   clk, rst                   clock, async active-high reset
//   rx_valid_i, rx_data_i      received byte strobe / byte
//   tx_valid_o, tx_data_o      response byte, held until tx_ready_i
//   tx_ready_i                 transmitter accepts response
//   mem_req_o, mem_gnt_i       word write request / accept
//   mem_addr_o, mem_wdata_o    word write byte address / data
//   fw_size_o                  firmware byte count from frame 0
//   busy_o                     frame in progress or response pending
//   done_o                     sticky, last payload frame ACKed
module uart_dbg_frame_rx #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] MAX_BYTES      = 32'd4096,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] fw_size_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NACK = 8'h15;

  typedef enum logic [1:0] {RECV, CHECK, WRITE, RESP} state_t;

  state_t          state, nstate;
  logic [5:0]      cnt;
  logic [15:0]     crc, rcv_crc;
  logic [32:0][7:0] fbuf;       // [0] index, [1..32] payload
  logic [7:0]      exp_idx, frames_wr;
  logic [2:0]      wi;
  logic [5:0]      wb;
  logic [31:0]     size_w, ceil_frames, word_addr, word_data;
  logic            ok, idx_match, idx_dup;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign ok          = (crc == rcv_crc);
  assign idx_match   = (fbuf[0] == exp_idx);
  assign idx_dup     = (exp_idx != 8'd0) && (fbuf[0] == exp_idx - 8'd1);
  assign size_w      = {fbuf[29], fbuf[30], fbuf[31], fbuf[32]};
  // frames needed = ceil(fw_size / 32), written without an add that could wrap
  assign ceil_frames = {5'd0, fw_size_o[31:5]} + {31'd0, |fw_size_o[4:0]};

  assign wb          = {1'b0, wi, 2'b00} + 6'd1;
  assign word_data   = {fbuf[wb + 6'd3], fbuf[wb + 6'd2], fbuf[wb + 6'd1], fbuf[wb]};
  assign word_addr   = BASE_ADDR + (({24'd0, fbuf[0]} - 32'd1) << 5) + {27'd0, wi, 2'b00};

  assign mem_req_o   = (state == WRITE);
  // address/data forced to zero when idle so reset really clears every output
  assign mem_addr_o  = mem_req_o ? word_addr : 32'd0;
  assign mem_wdata_o = mem_req_o ? word_data : 32'd0;
  assign tx_valid_o  = (state == RESP);
  assign busy_o      = (state != RECV) || (cnt != 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RECV;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      RECV:    if (rx_valid_i && cnt == 6'd34) nstate = CHECK;
      CHECK:   nstate = (ok && idx_match && exp_idx != 8'd0) ? WRITE : RESP;
      WRITE:   if (mem_gnt_i && wi == 3'd7) nstate = RESP;
      RESP:    if (tx_ready_i) nstate = RECV;
      default: nstate = RECV;
    endcase
  end

  // frame buffer needs no reset: it is always refilled before CHECK reads it
  always_ff @(posedge clk) begin
    if (state == RECV && rx_valid_i && cnt <= 6'd32) fbuf[cnt] <= rx_data_i;
  end

`ifdef UART_DBG_TIMEOUT_EN
  logic [15:0] tmr;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 6'd0;
      crc       <= 16'hFFFF;
      rcv_crc   <= 16'h0000;
      exp_idx   <= 8'd0;
      frames_wr <= 8'd0;
      wi        <= 3'd0;
      tx_data_o <= 8'h00;
      fw_size_o <= 32'd0;
      done_o    <= 1'b0;
`ifdef UART_DBG_TIMEOUT_EN
      tmr       <= 16'd0;
`endif
    end else begin
      case (state)
        RECV: begin
          if (rx_valid_i) begin
            cnt <= cnt + 6'd1;
            if (cnt >= 6'd1 && cnt <= 6'd32) crc <= crc_step(crc, rx_data_i);
            if (cnt == 6'd33) rcv_crc[7:0]  <= rx_data_i;
            if (cnt == 6'd34) rcv_crc[15:8] <= rx_data_i;
          end
`ifdef UART_DBG_TIMEOUT_EN
          if (rx_valid_i || cnt == 6'd0) tmr <= 16'd0;
          else if (tmr == TIMEOUT_CYCLES - 16'd1) begin
            tmr <= 16'd0;
            cnt <= 6'd0;
            crc <= 16'hFFFF;
          end else tmr <= tmr + 16'd1;
`endif
        end
        CHECK: begin
          wi        <= 3'd0;
          tx_data_o <= NACK;
          if (ok && idx_match) begin
            if (exp_idx == 8'd0 && size_w <= MAX_BYTES) begin
              fw_size_o <= size_w;
              exp_idx   <= 8'd1;
              frames_wr <= 8'd0;
              done_o    <= 1'b0;
              tx_data_o <= ACK;
            end
          end else if (ok && idx_dup) tx_data_o <= ACK;
        end
        WRITE: begin
          if (mem_gnt_i) begin
            wi <= wi + 3'd1;
            if (wi == 3'd7) begin
              exp_idx   <= exp_idx + 8'd1;
              frames_wr <= frames_wr + 8'd1;
              tx_data_o <= ACK;
            end
          end
        end
        RESP: begin
          if (tx_ready_i) begin
            cnt <= 6'd0;
            crc <= 16'hFFFF;
            if (tx_data_o == ACK && {24'd0, frames_wr} == ceil_frames) done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_frame_rx.sv
module tb_uart_dbg_frame_rx;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NACK = 8'h15;
  typedef logic [31:0][7:0] pl_t;

  logic        clk, rst;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        mem_req_o, mem_gnt_i;
  logic [31:0] mem_addr_o, mem_wdata_o, fw_size_o;
  logic        busy_o, done_o;

  uart_dbg_frame_rx dut (
    .clk(clk), .rst(rst), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .fw_size_o(fw_size_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;

  // environment state (written by the negedge process only)
  logic [31:0] wa[$], wd[$];
  logic [7:0]  rq[$];
  int req_cyc, mem_unstable, tx_unstable, stall_obs, held_obs;
  int st_cnt, hold_cnt, hold_seen;
  bit p_stall, p_txstall;
  logic [31:0] p_addr, p_data;
  logic [7:0]  p_txd;
  // controls (written by the stimulus process only)
  bit gnt_off, stall3;
  int hold_gen;

  // reference model state
  logic [7:0]  m_exp;
  logic [31:0] m_fw;
  int          m_fwr;
  bit          m_done;
  logic [31:0] ea[$], ed[$];

  always @(negedge clk) begin
    bit g, r;
    if (gnt_off) g = 1'b0;
    else if (stall3 && mem_req_o && mem_addr_o[4:2] == 3'd3) begin
      if (st_cnt < 5) begin g = 1'b0; st_cnt++; stall_obs++; end
      else g = 1'b1;
    end else g = 1'($urandom_range(0, 1));
    if (!(mem_req_o && mem_addr_o[4:2] == 3'd3)) st_cnt = 0;
    mem_gnt_i = g;
    if (p_stall && mem_req_o && (mem_addr_o != p_addr || mem_wdata_o != p_data)) mem_unstable++;
    p_stall = mem_req_o && !g;
    p_addr  = mem_addr_o;
    p_data  = mem_wdata_o;
    if (mem_req_o) req_cyc++;
    if (mem_req_o && g) begin wa.push_back(mem_addr_o); wd.push_back(mem_wdata_o); end

    if (hold_gen != hold_seen) begin hold_seen = hold_gen; hold_cnt = 10; end
    if (hold_cnt > 0 && tx_valid_o) begin r = 1'b0; hold_cnt--; held_obs++; end
    else r = ($urandom_range(0, 3) != 0);
    tx_ready_i = r;
    if (p_txstall && (!tx_valid_o || tx_data_o != p_txd)) tx_unstable++;
    p_txstall = tx_valid_o && !r;
    p_txd     = tx_data_o;
    if (tx_valid_o && r) rq.push_back(tx_data_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input pl_t pl);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      c = c ^ {8'h00, pl[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic pl_t rand_pl();
    pl_t p;
    for (int i = 0; i < 32; i++) p[i] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  function automatic pl_t make_pl0(input logic [31:0] sz);
    pl_t p = rand_pl();
    p[28] = sz[31:24]; p[29] = sz[23:16]; p[30] = sz[15:8]; p[31] = sz[7:0];
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    @(negedge clk);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk);
    rx_valid_i = 1'b0;
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] idx, input pl_t pl, input bit bad);
    logic [15:0] c = crc16(pl);
    pl_t q = pl;
    if (bad) q[$urandom_range(0, 31)] ^= 8'(1 << $urandom_range(0, 7));
    send_byte(idx, 2);
    for (int i = 0; i < 32; i++) send_byte(q[i], 2);
    send_byte(c[7:0], 2);
    send_byte(c[15:8], 2);
  endtask

  // expected behaviour straight from the frame rules
  task automatic model(input logic [7:0] idx, input pl_t pl, input bit bad, output logic [7:0] er);
    logic [31:0] sz;
    ea.delete(); ed.delete();
    er = NACK;
    if (!bad && idx == m_exp) begin
      if (m_exp == 8'd0) begin
        sz = {pl[28], pl[29], pl[30], pl[31]};
        if (sz <= 32'd4096) begin
          m_fw = sz; m_exp = 8'd1; m_fwr = 0; m_done = 1'b0; er = ACK;
        end
      end else begin
        for (int w = 0; w < 8; w++) begin
          ea.push_back(32'((int'(idx) - 1) * 32 + 4 * w));
          ed.push_back({pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]});
        end
        m_exp = m_exp + 8'd1; m_fwr++; er = ACK;
      end
    end else if (!bad && m_exp != 8'd0 && idx == m_exp - 8'd1) er = ACK;
    if (er == ACK && m_fwr == int'((m_fw + 32'd31) / 32'd32)) m_done = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] idx, input pl_t pl, input bit bad, input bit hold);
    int wb, rb, rc, ub, hb, to, nw;
    logic [7:0] er;
    model(idx, pl, bad, er);
    wb = wa.size(); rb = rq.size(); rc = req_cyc; ub = mem_unstable + tx_unstable; hb = held_obs;
    if (hold) hold_gen++;
    send_raw(idx, pl, bad);
    if (hold) begin
      to = 0;
      while (!tx_valid_o && to < 500) begin @(negedge clk); to++; end
      repeat (3) send_byte(8'($urandom_range(0, 255)), 0);
    end
    to = 0;
    while (rq.size() == rb && to < 2000) begin @(negedge clk); to++; end
    if (rq.size() == rb) begin chk("resp_timeout", 32'd0, 32'd1); return; end
    repeat (2) @(negedge clk);
    chk("resp", 32'(rq[rb]), 32'(er));
    chk("n_resp", 32'(rq.size() - rb), 32'd1);
    nw = wa.size() - wb;
    chk("n_writes", 32'(nw), 32'(ea.size()));
    for (int i = 0; i < 8 && i < nw && i < ea.size(); i++) begin
      chk("wr_addr", wa[wb+i], ea[i]);
      chk("wr_data", wd[wb+i], ed[i]);
    end
    if (ea.size() == 0) chk("req_cycles", 32'(req_cyc - rc), 32'd0);
    if (hold) chk("tx_held", 32'(held_obs - hb), 32'd10);
    chk("unstable", 32'(mem_unstable + tx_unstable - ub), 32'd0);
    chk("fw_size", fw_size_o, m_fw);
    chk("done", 32'(done_o), 32'(m_done));
    chk("busy_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_fw", fw_size_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_exp = 8'd0; m_fw = 32'd0; m_fwr = 0; m_done = 1'b0;
  endtask

  initial begin
    int s0, to, sel;
    logic [7:0] id;
    pl_t p;
    rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    gnt_off = 1'b0; stall3 = 1'b0; hold_gen = 0;
    m_exp = 8'd0; m_fw = 32'd0; m_fwr = 0; m_done = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // directed sequence
    run_frame(8'd0, make_pl0(32'h40), 1'b0, 1'b0);
    chk("fw_64", fw_size_o, 32'd64);
    run_frame(8'd1, rand_pl(), 1'b1, 1'b0);
    stall3 = 1'b1;
    s0 = stall_obs;
    p = rand_pl();
    run_frame(8'd1, p, 1'b0, 1'b0);
    chk("stall_cycles", 32'(stall_obs - s0), 32'd5);
    stall3 = 1'b0;
    run_frame(8'd1, p, 1'b0, 1'b0);
    run_frame(8'd3, rand_pl(), 1'b0, 1'b0);
    run_frame(8'd2, rand_pl(), 1'b0, 1'b1);
    chk("done_after_f2", 32'(done_o), 32'd1);

    // reset in the middle of a write burst
    gnt_off = 1'b1;
    send_raw(m_exp, rand_pl(), 1'b0);
    to = 0;
    while (!mem_req_o && to < 200) begin @(negedge clk); to++; end
    chk("req_before_rst", 32'(mem_req_o), 32'd1);
    repeat (3) @(negedge clk);
    do_reset();
    gnt_off = 1'b0;

    run_frame(8'd1, rand_pl(), 1'b0, 1'b0);
    run_frame(8'd0, make_pl0(32'h2000), 1'b0, 1'b0);
    run_frame(8'd0, make_pl0(32'd0), 1'b0, 1'b0);
    run_frame(8'd0, make_pl0(32'd4096), 1'b0, 1'b0);
    do_reset();
    run_frame(8'd0, make_pl0(32'd4096), 1'b0, 1'b0);
    run_frame(8'd0, make_pl0(32'd4097), 1'b0, 1'b0);

`ifdef UART_DBG_TIMEOUT_EN
    do_reset();
    s0 = rq.size();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 0);
    repeat (2500) @(negedge clk);
    chk("tmo_no_resp", 32'(rq.size() - s0), 32'd0);
    chk("tmo_busy", 32'(busy_o), 32'd0);
    run_frame(8'd0, make_pl0(32'd64), 1'b0, 1'b0);
`endif

    // randomized sequence against the model
    do_reset();
    run_frame(8'd0, make_pl0(32'($urandom_range(0, 300))), 1'b0, 1'b0);
    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      run_frame(m_exp, rand_pl(), 1'b0, 1'b0);
      else if (sel == 6) run_frame(m_exp, rand_pl(), 1'b1, 1'b0);
      else if (sel == 7) run_frame(m_exp - 8'd1, rand_pl(), 1'b0, 1'b0);
      else if (sel == 8) begin
        id = m_exp + 8'(1 + $urandom_range(0, 3));
        run_frame(id, rand_pl(), 1'b0, 1'b0);
      end else run_frame(8'd0, make_pl0(32'($urandom_range(0, 5000))), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
